// File: rtl/iobus_timer_if.sv
// iobus_timer_if: CPU I/O bus seen by the timer; master drives address/data/strobe, slave returns read data.
interface iobus_timer_if;
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] IOBUS_IN;
   modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input IOBUS_IN);
   modport slave (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/iobus_timer.sv
// iobus_timer: memory-mapped prescaled down-counter with one-shot/auto-reload modes and a level interrupt.
module iobus_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
   parameter int          PRE_W     = 16
) (
   input  logic           CLK,
   input  logic           RST,
   iobus_timer_if.slave   bus,
   output logic           INTR
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t            state;
   logic [2:0]        ctrl;
   logic [PRE_W-1:0]  prescale, pc;
   logic [31:0]       load, count, rdata;
   logic              exp, hit, wr_ctrl, wr_pre, wr_load, wr_st, tick, expire, unused_addr;
   logic [2:0]        off;
   assign hit         = bus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5];
   assign off         = bus.IOBUS_ADDR[4:2];
   assign unused_addr = ^bus.IOBUS_ADDR[1:0];
   assign wr_ctrl     = bus.IOBUS_WR && hit && off == 3'd0;
   assign wr_pre      = bus.IOBUS_WR && hit && off == 3'd1;
   assign wr_load     = bus.IOBUS_WR && hit && off == 3'd2;
   assign wr_st       = bus.IOBUS_WR && hit && off == 3'd4;
   // Register writes and a pause take priority over the prescaler on the same edge.
   assign tick   = state == RUN && pc == prescale && !wr_load && !wr_pre && !(wr_ctrl && !bus.IOBUS_OUT[0]);
   assign expire = tick && count == 32'd0;
   assign INTR   = exp & ctrl[2];
   always_comb begin
      rdata = !hit       ? 32'd0 :
              off == 3'd0 ? {29'd0, ctrl} :
              off == 3'd1 ? 32'(prescale) :
              off == 3'd2 ? load :
              off == 3'd3 ? count :
              off == 3'd4 ? {31'd0, exp} : 32'd0;
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state        <= IDLE;
         ctrl         <= '0;
         prescale     <= '0;
         pc           <= '0;
         load         <= '0;
         count        <= '0;
         exp          <= 1'b0;
         bus.IOBUS_IN <= '0;
      end else begin
         bus.IOBUS_IN <= rdata;
         exp          <= expire | (exp & ~(wr_st & bus.IOBUS_OUT[0]));
         if (state == RUN && !wr_load && !wr_pre && !(wr_ctrl && !bus.IOBUS_OUT[0])) begin
            if (!tick) pc <= pc + 1'b1;
            else begin
               pc <= '0;
               if (!expire) count <= count - 32'd1;
               else if (ctrl[1]) count <= load;
               else state <= DONE;
            end
         end
         if (wr_ctrl) begin
            ctrl <= bus.IOBUS_OUT[2:0];
            if (!bus.IOBUS_OUT[0]) state <= IDLE;
            else if (state == IDLE) begin
               state <= RUN;
               if (count == 32'd0) count <= load;
            end else if (state == DONE) begin
               state <= RUN;
               count <= load;
               pc    <= '0;
            end
         end
         if (wr_pre) begin
            prescale <= bus.IOBUS_OUT[PRE_W-1:0];
            pc       <= '0;
         end
         if (wr_load) begin
            load  <= bus.IOBUS_OUT;
            count <= bus.IOBUS_OUT;
            pc    <= '0;
         end
      end
   end
endmodule
